// File: rtl/riscv_hazard_pkg.sv
// -----------------------------------------------------------------------------
// riscv_hazard_pkg
// Shared constants and types for the load-use hazard unit.
//   REG_AW_DEF      default register address width
//   LOAD_LAT_MAX    largest supported load latency (scoreboard depth)
//   lsb_slot_t      one scoreboard entry {valid, rd} at the default width
//   stall_threshold number of scoreboard slots a source must be checked against
// -----------------------------------------------------------------------------
package riscv_hazard_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LOAD_LAT_MAX = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
  } lsb_slot_t;

  // ALU operands are needed at the start of EX, so every in-flight load slot
  // counts. Store data is only consumed in MEM, which buys one extra stage.
  function automatic logic [2:0] stall_threshold(input int unsigned load_lat,
                                                 input logic        store_data);
    if (store_data) stall_threshold = 3'(load_lat - 1);
    else            stall_threshold = 3'(load_lat);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Compares one ID-stage source register against the scoreboard slots younger
// than a threshold and reports a read-after-load match.
// Ports:
//   rs_i          source register address
//   use_i         operand is actually read by the instruction
//   thresh_i      only slots k < thresh_i can cause a match
//   slot_valid_i  per-slot valid bits, slot 0 in bit 0
//   slot_rd_i     per-slot destination, slot k at [k*REG_AW +: REG_AW]
//   match_o       1 when this source must wait
// -----------------------------------------------------------------------------
module hazard_src_match
  import riscv_hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic [REG_AW-1:0]          rs_i,
  input  logic                       use_i,
  input  logic [2:0]                 thresh_i,
  input  logic [LOAD_LAT-1:0]        slot_valid_i,
  input  logic [LOAD_LAT*REG_AW-1:0] slot_rd_i,
  output logic                       match_o
);

  always_comb begin
    // NOTE: a default before any conditional assignment keeps always_comb from inferring a latch.
    match_o = 1'b0;
    // x0 is hard-wired to zero, so a read of it never depends on a load.
    if (use_i && (rs_i != '0)) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if ((k < int'(thresh_i)) && slot_valid_i[k] &&
            (slot_rd_i[k*REG_AW +: REG_AW] == rs_i)) begin
          match_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// load_use_scoreboard
// Load-use hazard unit: a LOAD_LAT-deep shift register of in-flight load
// destinations is compared against the ID-stage sources to produce the IF/ID
// write enable and the ID/EX bubble.
// Build option: define HAZARD_PERF_EN to enable the saturating stall counter;
// otherwise stall_cycles is tied to zero.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   id_rs          ID source addresses, src0 in the LSBs
//   id_use         per-source "operand is read" mask
//   id_is_store    ID is a store (src1 is store data)
//   id_is_load     ID is a load
//   id_rd          ID destination register
//   ex_flush       taken branch/jump in EX, kills the ID instruction
//   pipe_hold      global freeze, scoreboard holds
//   if_we          PC / IF/ID write enable
//   id_ex_bubble   zero the ID/EX control fields
//   hazard         raw hazard flag
//   stall_cycles   hazard stall counter
// -----------------------------------------------------------------------------
module load_use_scoreboard
  import riscv_hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_use,
  input  logic                      id_is_store,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      ex_flush,
  input  logic                      pipe_hold,
  output logic                      if_we,
  output logic                      id_ex_bubble,
  output logic                      hazard,
  output logic [31:0]               stall_cycles
);

  // Slot k sits k stages beyond EX; slot 0 is the instruction now in EX.
  logic [LOAD_LAT-1:0]        slot_valid_q, slot_valid_d;
  logic [LOAD_LAT*REG_AW-1:0] slot_rd_q,    slot_rd_d;

  logic [NUM_SRC-1:0] src_match;
  logic               issue;
  logic               push_valid;
  logic [REG_AW-1:0]  push_rd;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [2:0] thresh;
    assign thresh = stall_threshold(LOAD_LAT, (s == 1) && id_is_store);

    hazard_src_match #(
      .LOAD_LAT (LOAD_LAT),
      .REG_AW   (REG_AW)
    ) u_match (
      .rs_i         (id_rs[s*REG_AW +: REG_AW]),
      .use_i        (id_use[s]),
      .thresh_i     (thresh),
      .slot_valid_i (slot_valid_q),
      .slot_rd_i    (slot_rd_q),
      .match_o      (src_match[s])
    );
  end

  assign hazard       = |src_match;
  // A flush kills the stalled instruction anyway, so it overrides the stall.
  assign if_we        = ~hazard | ex_flush;
  assign id_ex_bubble =  hazard | ex_flush;

  assign issue      = ~hazard & ~ex_flush;
  assign push_valid = issue & id_is_load & (id_rd != '0);
  assign push_rd    = push_valid ? id_rd : '0;

  if (LOAD_LAT == 1) begin : g_shift1
    assign slot_valid_d = push_valid;
    assign slot_rd_d    = push_rd;
  end else begin : g_shiftn
    assign slot_valid_d = {slot_valid_q[LOAD_LAT-2:0], push_valid};
    assign slot_rd_d    = {slot_rd_q[(LOAD_LAT-1)*REG_AW-1:0], push_rd};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      slot_valid_q <= '0;
      slot_rd_q    <= '0;
    end else if (!pipe_hold) begin
      slot_valid_q <= slot_valid_d;
      slot_rd_q    <= slot_rd_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !ex_flush && !pipe_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_load_use_scoreboard
// Two DUT instances (LOAD_LAT=1 and LOAD_LAT=3). A driver applies directed
// instruction vectors and queues the expected {hazard, if_we, id_ex_bubble}
// per cycle; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_load_use_scoreboard;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] rs;
    logic [1:0] use_m;
    logic       st;
    logic       ld;
    logic [4:0] rd;
    logic       fl;
    logic       hold;
  } tb_in_t;

  typedef struct packed {
    logic        sel;
    logic [2:0]  exp;   // {hazard, if_we, id_ex_bubble}
    logic        cc;
    logic [31:0] ec;
  } exp_t;

  localparam tb_in_t IDLE = '0;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  tb_in_t in0 = '0;
  tb_in_t in1 = '0;

  logic        we0, bub0, haz0;
  logic        we1, bub1, haz1;
  logic [31:0] cnt0, cnt1;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  load_use_scoreboard #(.LOAD_LAT(1), .NUM_SRC(2), .REG_AW(5)) u_lat1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (in0.rs),
    .id_use       (in0.use_m),
    .id_is_store  (in0.st),
    .id_is_load   (in0.ld),
    .id_rd        (in0.rd),
    .ex_flush     (in0.fl),
    .pipe_hold    (in0.hold),
    .if_we        (we0),
    .id_ex_bubble (bub0),
    .hazard       (haz0),
    .stall_cycles (cnt0)
  );

  load_use_scoreboard #(.LOAD_LAT(3), .NUM_SRC(2), .REG_AW(5)) u_lat3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (in1.rs),
    .id_use       (in1.use_m),
    .id_is_store  (in1.st),
    .id_is_load   (in1.ld),
    .id_rd        (in1.rd),
    .ex_flush     (in1.fl),
    .pipe_hold    (in1.hold),
    .if_we        (we1),
    .id_ex_bubble (bub1),
    .hazard       (haz1),
    .stall_cycles (cnt1)
  );

  // One cycle of stimulus on instance sel (the other instance idles) and the
  // expected outputs for that same cycle.
  task automatic step(input bit sel, input bit rst,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] use_m, input bit st, input bit ld,
                      input logic [4:0] rd, input bit fl, input bit hold,
                      input bit eh, input bit cc, input logic [31:0] ec,
                      input string nm);
    tb_in_t v;
    exp_t   e;
    @(posedge clk);
    #1;
    v.rs = {rs1, rs0}; v.use_m = use_m; v.st = st; v.ld = ld;
    v.rd = rd; v.fl = fl; v.hold = hold;
    rst_n = ~rst;
    if (sel) begin in1 = v; in0 = IDLE; end
    else     begin in0 = v; in1 = IDLE; end
    e.sel = sel;
    e.exp = {eh, ~eh | fl, eh | fl};
    e.cc  = cc;
    e.ec  = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Shorthands: load, idle, and generic op on the selected instance.
  task automatic lw(input bit sel, input logic [4:0] rd, input string nm);
    step(sel, 0, 5'd2, 5'd0, 2'b01, 0, 1, rd, 0, 0, 0, 0, 0, nm);
  endtask

  task automatic nop(input bit sel, input bit rst, input bit cc,
                     input logic [31:0] ec, input string nm);
    step(sel, rst, 5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 0, 0, cc, ec, nm);
  endtask

  task automatic op(input bit sel, input logic [4:0] rs0, input logic [4:0] rs1,
                    input logic [1:0] use_m, input bit st, input bit fl,
                    input bit hold, input bit rst, input bit eh, input string nm);
    step(sel, rst, rs0, rs1, use_m, st, 0, 5'd9, fl, hold, eh, 0, 0, nm);
  endtask

  // Monitor: compares the queued expectation against the live outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      string       nm;
      logic [2:0]  act;
      logic [31:0] cnt;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = e.sel ? {haz1, we1, bub1} : {haz0, we0, bub0};
      cnt = e.sel ? cnt1 : cnt0;
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: hazard/if_we/bubble got %b want %b", nm, act, e.exp);
      end
      if (e.cc) begin
        total++;
        if (cnt !== e.ec) begin
          bad++;
          $display("FAIL %s: stall_cycles got %0d want %0d", nm, cnt, e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset both instances; outputs quiet, counters zero.
    nop(0, 1, 1, 32'd0, "rst_a_l1");
    nop(1, 1, 1, 32'd0, "rst_b_l3");
    nop(0, 0, 1, 32'd0, "post_rst_l1");

    // LOAD_LAT=1: lw x5 ; add x6,x5,x1 -> one stall cycle.
    lw (0, 5'd5, "l1_lw_a");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 1, "l1_dep_stall");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 0, "l1_dep_issue");

    // lw x5 ; sw x5,0(x2): store data never stalls at LOAD_LAT=1.
    lw (0, 5'd5, "l1_lw_b");
    op (0, 5'd2, 5'd5, 2'b11, 1, 0, 0, 0, 0, "l1_st_data");

    // lw x5 ; sw x2,0(x5): base address stalls once.
    lw (0, 5'd5, "l1_lw_c");
    op (0, 5'd5, 5'd2, 2'b11, 1, 0, 0, 0, 1, "l1_st_base_stall");
    op (0, 5'd5, 5'd2, 2'b11, 1, 0, 0, 0, 0, "l1_st_base_issue");

    // lw x0 ; add x1,x0,x0: x0 is never tracked.
    lw (0, 5'd0, "l1_lw_x0");
    op (0, 5'd0, 5'd0, 2'b11, 0, 0, 0, 0, 0, "l1_x0_nostall");

    // lw x5 ; LUI with rs1 field = 5 but no operands used.
    lw (0, 5'd5, "l1_lw_d");
    op (0, 5'd5, 5'd5, 2'b00, 0, 0, 0, 0, 0, "l1_lui_nostall");

    // Flush during a stall: no stall, bubble, then the load has drained.
    lw (0, 5'd5, "l1_lw_e");
    op (0, 5'd5, 5'd1, 2'b11, 0, 1, 0, 0, 1, "l1_flush_override");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 0, "l1_drained");

    // Two-cycle pipe_hold during a stall extends it by two cycles.
    lw (0, 5'd5, "l1_lw_f");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 1, 0, 1, "l1_hold1");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 1, 0, 1, "l1_hold2");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 1, "l1_hold_release_stall");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 0, "l1_hold_issue");

    // Reset mid-stall clears the pending load.
    lw (0, 5'd5, "l1_lw_g");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 1, 1, "l1_rst_in_stall");
    op (0, 5'd5, 5'd1, 2'b11, 0, 0, 0, 0, 0, "l1_after_rst");

    // LOAD_LAT=3: lw x7 ; dependent op -> three stalls, counter at 3.
    lw (1, 5'd7, "l3_lw_a");
    op (1, 5'd1, 5'd7, 2'b11, 0, 0, 0, 0, 1, "l3_stall1");
    op (1, 5'd1, 5'd7, 2'b11, 0, 0, 0, 0, 1, "l3_stall2");
    op (1, 5'd1, 5'd7, 2'b11, 0, 0, 0, 0, 1, "l3_stall3");
    step(1, 0, 5'd1, 5'd7, 2'b11, 0, 0, 5'd9, 0, 0, 0, 1, PERF ? 32'd3 : 32'd0,
         "l3_issue_cnt3");

    // Two independent ops between load and use -> one stall.
    lw (1, 5'd7, "l3_lw_b");
    nop(1, 0, 0, 32'd0, "l3_indep1");
    nop(1, 0, 0, 32'd0, "l3_indep2");
    op (1, 5'd7, 5'd0, 2'b01, 0, 0, 0, 0, 1, "l3_gap_stall");
    op (1, 5'd7, 5'd0, 2'b01, 0, 0, 0, 0, 0, "l3_gap_issue");

    // Store data at LOAD_LAT=3 waits LOAD_LAT-1 = 2 cycles.
    lw (1, 5'd7, "l3_lw_c");
    op (1, 5'd2, 5'd7, 2'b11, 1, 0, 0, 0, 1, "l3_st_stall1");
    op (1, 5'd2, 5'd7, 2'b11, 1, 0, 0, 0, 1, "l3_st_stall2");
    step(1, 0, 5'd2, 5'd7, 2'b11, 1, 0, 5'd9, 0, 0, 0, 1, PERF ? 32'd6 : 32'd0,
         "l3_st_issue_cnt6");

    // Reset clears the counter.
    nop(1, 1, 0, 32'd0, "l3_rst");
    nop(1, 0, 1, 32'd0, "l3_cnt_cleared");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Parametrised load-use hazard unit for the RISC-V pipeline. It replaces single-cycle load-use detection with a shift-register scoreboard that tracks in-flight loads across a configurable load latency. Each cycle it compares the ID-stage source registers against every pending load destination and produces the IF/ID write enable and the ID/EX bubble. It sits between the ID decoder, the ID/EX register and the branch-flush logic.

## Interface
Parameters:
- LOAD_LAT, 1: number of stall cycles a dependent ALU op needs behind a load; legal range 1..4. The classic 5-stage pipe uses 1.
- NUM_SRC, 2: number of source operands; 2 or 3 (3 adds rs3 for R4-type).
- REG_AW, 5: register address width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_rs  in  NUM_SRC*REG_AW  ID source addresses; src0 occupies the LSBs.
- id_use  in  NUM_SRC  per-source "operand is read" mask. LUI, JAL and AUIPC clear all bits.
- id_is_store  in  1  ID instruction is a store; src1 is its store data.
- id_is_load  in  1  ID instruction is a load.
- id_rd  in  REG_AW  ID destination register.
- ex_flush  in  1  taken branch or jump in EX; kills the ID instruction.
- pipe_hold  in  1  global freeze (memory wait); the scoreboard holds its contents.
- if_we  out  1  PC and IF/ID write enable; 0 while a hazard is present.
- id_ex_bubble  out  1  zero the control fields written into ID/EX.
- hazard  out  1  raw hazard flag (debug).
- stall_cycles  out  32  hazard stall counter (see Configuration).

## Operation
- Scoreboard: LOAD_LAT slots, slot[0..LOAD_LAT-1]. Each slot holds {valid, rd}. slot[0] is the instruction in EX; slot[k] is k stages beyond EX.
- Match on source s, slot k: id_use[s] & id_rs[s]!=0 & slot[k].valid & slot[k].rd==id_rs[s].
- Stall thresholds:
  - ALU sources stall when a match exists with k < LOAD_LAT.
  - Store-data source (src1 with id_is_store) stalls only when k < LOAD_LAT-1, because store data is consumed in MEM. With LOAD_LAT=1, store data therefore never stalls.
- hazard is the OR over all sources.
- Outputs:
  - if_we = ~hazard | ex_flush.
  - id_ex_bubble = hazard | ex_flush.
  - Flush overrides stall.
- Issue: issue = ~hazard & ~ex_flush. When the ID instruction issues and is a load with id_rd!=0, it is pushed as {1, id_rd}. Otherwise a bubble {0, x} is pushed.
- Shift, on each edge with pipe_hold=0: slot[0] takes the push value and slot[k] takes slot[k-1]; the oldest slot is dropped.
- pipe_hold=1: all slots hold. Outputs are still computed from the held state.
- x0 is never tracked or matched.

## Timing
- hazard, if_we and id_ex_bubble are combinational from the inputs and the slots, valid in the same cycle. There is no register on the output path.
- A dependent ALU op is stalled for exactly LOAD_LAT cycles when it directly follows a load, and for LOAD_LAT-d cycles when d independent instructions separate them (minimum 0).
- Reset (rst_n=0 at an edge): all slots invalid, stall_cycles=0. Afterwards, with ex_flush=0, if_we=1, id_ex_bubble=0 and hazard=0.
- Reset asserted mid-stall clears all pending loads; there is no stall on the next cycle.
- Simultaneous ex_flush and hazard: no stall, bubble inserted, nothing pushed.
- pipe_hold together with hazard: the state freezes and the stall persists until the hold releases.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles increments, saturating at 32'hFFFF_FFFF, on every edge with hazard=1, ex_flush=0, pipe_hold=0 and rst_n=1.
- HAZARD_PERF_EN undefined: the counter is absent and stall_cycles is tied to 0. The port list is identical in both builds.

## Structure
- Package riscv_hazard_pkg:
  - REG_AW_DEF=5 and LOAD_LAT_MAX=4.
  - Typedef lsb_slot_t {logic valid; logic [REG_AW-1:0] rd}.
- Sub-module hazard_src_match, instantiated once per source. It compares one source against all slots against the given threshold and returns a 1-bit match.

## Test plan
- LOAD_LAT=1: issue `lw x5`, then `add x6,x5,x1` next cycle -> if_we=0 and id_ex_bubble=1 for exactly 1 cycle; add issues on the 2nd cycle.
- LOAD_LAT=3: `lw x7`, then a dependent op -> 3 stall cycles. With two independent ops between them -> 1 stall cycle.
- `lw x5`, then `sw x5,0(x2)` (store data) with LOAD_LAT=1 -> no stall. The same pair with `sw x2,0(x5)` (base) -> 1 stall.
- `lw x0`, then `add x1,x0,x0` -> no stall. LUI with rs1 field =5 after `lw x5` (id_use=0) -> no stall.
- Stall in progress with ex_flush=1 -> if_we=1, id_ex_bubble=1; the load still drains. A pipe_hold pulse of 2 cycles extends the stall by 2.
- rst_n=0 during a stall -> the next cycle has if_we=1. With HAZARD_PERF_EN defined, stall_cycles counts 3 after the LOAD_LAT=3 case, then resets to 0.
